// File: rtl/ram_pkg.sv
// Shared defaults and FSM state encoding for the single-port RAM controller.
package ram_pkg;

   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned ADDR_W_DEF = 8;
   localparam int unsigned DEPTH_DEF  = 11;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      WRITE  = 3'd2,
      HOLD   = 3'd3,
      SAMPLE = 3'd4,
      RESP   = 3'd5
   } state_t;

endpackage

// File: rtl/ram_ctrl.sv
// Request/response front end for an asynchronous-read RAM with a multi-cycle,
// setup/hold-protected write strobe.
module ram_ctrl
   import ram_pkg::*;
#(
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned ADDR_W    = ADDR_W_DEF,
   parameter int unsigned DEPTH     = DEPTH_DEF,
   parameter int unsigned WR_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] data_in,
   output logic              writeOn,
   input  logic [DATA_W-1:0] data_out
);

   localparam int unsigned     CNT_W    = 4;
   localparam int unsigned     AW1      = ADDR_W + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WR_CYCLES - 1);
   localparam logic [AW1-1:0]  DEPTH_L  = AW1'(DEPTH);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              we_q, we_nxt;
   logic [ADDR_W-1:0] address_nxt;
   logic [DATA_W-1:0] data_in_nxt;
   logic [DATA_W-1:0] rsp_data_nxt;
   logic              rsp_err_nxt;
   logic              req_ready_nxt;
   logic              rsp_valid_nxt;
   logic              write_on_nxt;
   logic              illegal_c;

   assign illegal_c = ({1'b0, req_addr} >= DEPTH_L);

   // State and every output are registered; outputs are precomputed from state_nxt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         we_q      <= 1'b0;
         address   <= '0;
         data_in   <= '0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         writeOn   <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         we_q      <= we_nxt;
         address   <= address_nxt;
         data_in   <= data_in_nxt;
         rsp_data  <= rsp_data_nxt;
         rsp_err   <= rsp_err_nxt;
         req_ready <= req_ready_nxt;
         rsp_valid <= rsp_valid_nxt;
         writeOn   <= write_on_nxt;
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      we_nxt       = we_q;
      address_nxt  = address;
      data_in_nxt  = data_in;
      rsp_data_nxt = rsp_data;
      rsp_err_nxt  = rsp_err;

      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               we_nxt       = req_we;
               rsp_data_nxt = '0;
               if (illegal_c) begin
                  // Out-of-range: answer immediately, leave the RAM port untouched.
                  rsp_err_nxt = 1'b1;
                  state_nxt   = RESP;
               end else begin
                  rsp_err_nxt = 1'b0;
                  address_nxt = req_addr;
                  if (req_we) begin
                     data_in_nxt = req_wdata;
                  end
                  state_nxt = SETUP;
               end
            end
         end
         SETUP: begin
            cnt_nxt   = '0;
            state_nxt = we_q ? WRITE : SAMPLE;
         end
         WRITE: begin
            if (cnt == CNT_LAST) begin
               state_nxt = HOLD;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         HOLD: begin
            state_nxt = RESP;
         end
         SAMPLE: begin
            rsp_data_nxt = data_out;
            state_nxt    = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      req_ready_nxt = (state_nxt == IDLE);
      rsp_valid_nxt = (state_nxt == RESP);
      write_on_nxt  = (state_nxt == WRITE);
   end

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl: vector table on a WR_CYCLES=1 instance plus
// stall, ignore-while-busy and mid-write reset sequences on a WR_CYCLES=4 instance.
`timescale 1ns/1ps
module tb_ram_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: WR_CYCLES = 1
   logic       rst_n, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err, writeOn;
   logic [7:0] req_addr, req_wdata, rsp_data, address, data_in, data_out;
   // Instance B: WR_CYCLES = 4
   logic       rst_n2, req_valid2, req_ready2, req_we2, rsp_valid2, rsp_ready2, rsp_err2, writeOn2;
   logic [7:0] req_addr2, req_wdata2, rsp_data2, address2, data_in2, data_out2;

   logic [7:0] mem  [0:255];
   logic [7:0] mem2 [0:255];

   ram_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(11), .WR_CYCLES(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_err(rsp_err), .address(address), .data_in(data_in),
      .writeOn(writeOn), .data_out(data_out));

   ram_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(11), .WR_CYCLES(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n2), .req_valid(req_valid2), .req_ready(req_ready2),
      .req_we(req_we2), .req_addr(req_addr2), .req_wdata(req_wdata2),
      .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_data(rsp_data2),
      .rsp_err(rsp_err2), .address(address2), .data_in(data_in2),
      .writeOn(writeOn2), .data_out(data_out2));

   // RAM models: combinational read, write while the strobe is high.
   assign data_out  = mem[address];
   assign data_out2 = mem2[address2];
   always @(posedge clk) if (writeOn)  mem[address]   <= data_in;
   always @(posedge clk) if (writeOn2) mem2[address2] <= data_in2;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
      int         lat;
      logic       err;
      logic [7:0] data;
      int         won;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic we, input logic [7:0] a, input logic [7:0] wd,
                               input int lat, input logic err, input logic [7:0] d, input int won);
      vec_t v;
      v.we = we; v.addr = a; v.wdata = wd; v.lat = lat; v.err = err; v.data = d; v.won = won;
      return v;
   endfunction

   // One full transaction on instance A, handshake included.
   task automatic run_txn(input string tag, input vec_t v);
      int         lat, won;
      logic       ok;
      logic [7:0] addr_before;
      addr_before = address;
      chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
      tick();
      req_valid = 1'b0;
      lat = 1; won = 0; ok = 1'b1;
      while (!rsp_valid && lat < 40) begin
         if (writeOn) won++;
         if (v.err) begin
            if (address !== addr_before) ok = 1'b0;
         end else begin
            if (address !== v.addr) ok = 1'b0;
            if (v.we && data_in !== v.wdata) ok = 1'b0;
         end
         tick();
         lat++;
      end
      chk({tag, " latency"},     32'(lat),      32'(v.lat));
      chk({tag, " rsp_err"},     32'(rsp_err),  32'(v.err));
      chk({tag, " rsp_data"},    32'(rsp_data), 32'(v.data));
      chk({tag, " writeOn_cyc"}, 32'(won),      32'(v.won));
      chk({tag, " port_stable"}, 32'(ok),       32'd1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk({tag, " post_valid"},  32'(rsp_valid), 32'd0);
      chk({tag, " post_ready"},  32'(req_ready), 32'd1);
   endtask

   initial begin
      int lat, won;
      for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; mem2[i] = 8'h00; end
      rst_n = 1'b0; rst_n2 = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
      req_valid2 = 1'b0; req_we2 = 1'b0; req_addr2 = '0; req_wdata2 = '0; rsp_ready2 = 1'b0;

      // Reset state
      #3;
      chk("reset outputs", 32'({req_ready, rsp_valid, rsp_err, writeOn, rsp_data, address, data_in}), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1; rst_n2 = 1'b1;
      #1;
      chk("ready before edge", 32'(req_ready), 32'd0);
      tick();
      chk("ready after edge", 32'(req_ready), 32'd1);
      chk("ready2 after edge", 32'(req_ready2), 32'd1);

      // Vector table
      vecs.push_back(mk(1'b1, 8'd3,   8'hA5, 4, 1'b0, 8'h00, 1));
      vecs.push_back(mk(1'b0, 8'd3,   8'h00, 3, 1'b0, 8'hA5, 0));
      vecs.push_back(mk(1'b0, 8'd11,  8'h00, 1, 1'b1, 8'h00, 0));
      vecs.push_back(mk(1'b1, 8'd11,  8'h5A, 1, 1'b1, 8'h00, 0));
      vecs.push_back(mk(1'b1, 8'd200, 8'h77, 1, 1'b1, 8'h00, 0));
      for (int i = 0; i < 11; i++)
         vecs.push_back(mk(1'b1, 8'(i), 8'(8'h11 + i), 4, 1'b0, 8'h00, 1));
      for (int i = 0; i < 11; i++)
         vecs.push_back(mk(1'b0, 8'(i), 8'h00, 3, 1'b0, 8'(8'h11 + i), 0));
      foreach (vecs[i]) run_txn($sformatf("vec%0d", i), vecs[i]);
      chk("ram word 11 untouched", 32'(mem[11]), 32'd0);

      // Stalled read of addr 10 with a write request ignored while busy
      req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd10;
      tick();
      req_we = 1'b1; req_addr = 8'd5; req_wdata = 8'hEE;
      lat = 1;
      while (!rsp_valid && lat < 40) begin tick(); lat++; end
      chk("stall latency", 32'(lat), 32'd3);
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("stall%0d hold", c), 32'({rsp_valid, rsp_err, rsp_data}), 32'({1'b1, 1'b0, 8'h1B}));
         chk($sformatf("stall%0d ready", c), 32'({req_ready, writeOn}), 32'd0);
         tick();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("stall release", 32'({rsp_valid, req_ready}), 32'b01);
      run_txn("ignored_write", mk(1'b0, 8'd5, 8'h00, 3, 1'b0, 8'h16, 0));

      // Instance B: full write with WR_CYCLES = 4
      req_valid2 = 1'b1; req_we2 = 1'b1; req_addr2 = 8'd1; req_wdata2 = 8'h77;
      tick();
      req_valid2 = 1'b0;
      lat = 1; won = 0;
      while (!rsp_valid2 && lat < 40) begin
         if (writeOn2) won++;
         tick();
         lat++;
      end
      chk("wr4 latency", 32'(lat), 32'd7);
      chk("wr4 writeOn_cyc", 32'(won), 32'd4);
      chk("wr4 ram", 32'(mem2[1]), 32'h77);
      rsp_ready2 = 1'b1;
      tick();
      rsp_ready2 = 1'b0;

      // Instance B: reset during the second WRITE cycle
      req_valid2 = 1'b1; req_we2 = 1'b1; req_addr2 = 8'd0; req_wdata2 = 8'h3C;
      tick();
      req_valid2 = 1'b0;
      chk("rst setup writeOn", 32'(writeOn2), 32'd0);
      tick();
      chk("rst write1 writeOn", 32'(writeOn2), 32'd1);
      tick();
      chk("rst write2 writeOn", 32'(writeOn2), 32'd1);
      #2 rst_n2 = 1'b0;
      #1;
      chk("rst async drop", 32'({writeOn2, rsp_valid2, req_ready2, address2, data_in2}), 32'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("rst hold%0d", c), 32'({writeOn2, rsp_valid2, req_ready2}), 32'd0);
      end
      @(negedge clk);
      rst_n2 = 1'b1;
      tick();
      chk("rst ready after release", 32'({req_ready2, rsp_valid2}), 32'b10);
      for (int c = 0; c < 6; c++) begin
         tick();
         chk($sformatf("rst no rsp%0d", c), 32'({rsp_valid2, writeOn2}), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/ram_ctrl.md
RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 Parameter DATA_W, default 8: data width of request, response and RAM data ports.
REQ-002 Parameter ADDR_W, default 8: address width of request and RAM address port.
REQ-003 Parameter DEPTH, default 11: number of valid RAM words; addresses 0..DEPTH-1 are legal.
REQ-004 Parameter WR_CYCLES, default 1 (range 1..15): cycles writeOn is held high per write.
REQ-005 Interface is decided as follows: one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  sole clock; all state changes on the rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 req_valid  input  1  request present.
REQ-009 req_ready  output  1  controller can accept a request.
REQ-010 req_we  input  1  1 = write, 0 = read.
REQ-011 req_addr  input  ADDR_W  target word address.
REQ-012 req_wdata  input  DATA_W  write data.
REQ-013 rsp_valid  output  1  response present.
REQ-014 rsp_ready  input  1  consumer accepts the response.
REQ-015 rsp_data  output  DATA_W  read data; 0 for writes and errors.
REQ-016 rsp_err  output  1  request address out of range.
REQ-017 address  output  ADDR_W  RAM address port.
REQ-018 data_in  output  DATA_W  RAM write data port.
REQ-019 writeOn  output  1  RAM write enable, level-sensitive.
REQ-020 data_out  input  DATA_W  RAM combinational read data.

Function
REQ-021 FSM states SHALL be IDLE, SETUP, WRITE, HOLD, SAMPLE, RESP.
REQ-022 req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle where req_valid && req_ready, and addr/we/wdata are registered then.
REQ-023 Accepted legal write: IDLE -> SETUP (address/data_in driven, writeOn=0) -> WRITE for WR_CYCLES cycles (writeOn=1) -> HOLD one cycle (writeOn=0, address/data_in unchanged) -> RESP.
REQ-024 Accepted legal read: IDLE -> SETUP (address driven, writeOn=0) -> SAMPLE (data_out registered into rsp_data at end of cycle) -> RESP.
REQ-025 Latency from accept edge to rsp_valid high: read 3 cycles; write 3+WR_CYCLES cycles.
REQ-026 Request with req_addr >= DEPTH: IDLE -> RESP next cycle, rsp_err=1, rsp_data=0, writeOn never asserted, address not updated.
REQ-027 In RESP, rsp_valid=1 and rsp_data/rsp_err SHALL hold stable until rsp_valid && rsp_ready, then return to IDLE the next cycle.
REQ-028 Back-to-back: minimum one IDLE cycle between a response handshake and the next accept.
REQ-029 writeOn SHALL be 1 only in WRITE; address and data_in SHALL not change while writeOn=1 nor in the cycle before or after.
REQ-030 writeOn SHALL be a direct register output (glitch-free), never decoded combinationally.
REQ-031 rsp_err SHALL be 0 for legal requests; rsp_data SHALL be 0 for writes.
REQ-032 req_valid while not in IDLE SHALL be ignored (no accept, no side effect).

Reset
REQ-033 rst_n low SHALL immediately force state IDLE, writeOn=0, rsp_valid=0, rsp_err=0, rsp_data=0, address=0, data_in=0, req_ready=0 while asserted.
REQ-034 Reset mid-write SHALL drop writeOn asynchronously; the RAM word content is then undefined and the request is lost with no response.
REQ-035 req_ready SHALL rise on the first clock edge after rst_n deasserts.

Structure
REQ-036 A shared package ram_pkg SHALL hold the default DATA_W/ADDR_W/DEPTH constants and the FSM state enumeration typedef.
REQ-037 No sub-module; the WR_CYCLES counter and FSM live in ram_ctrl; the RAM model is instantiated only in the bench.

Verification
REQ-038 Reset then write addr 3 data 0xA5, WR_CYCLES=1 -> writeOn high exactly 1 cycle with address=3, data_in=0xA5; rsp_valid 4 cycles after accept, rsp_err=0.
REQ-039 Read addr 3 after REQ-038 -> rsp_valid 3 cycles after accept, rsp_data=0xA5.
REQ-040 Read addr 11 (DEPTH=11) -> rsp_valid 1 cycle after accept, rsp_err=1, rsp_data=0, writeOn stays 0.
REQ-041 Read addr 10 with rsp_ready low 5 cycles -> rsp_valid and rsp_data stable 5 cycles, req_ready 0 throughout, IDLE after handshake.
REQ-042 WR_CYCLES=4, write addr 0 data 0x3C, rst_n low in the 2nd WRITE cycle -> writeOn 0 same cycle, no rsp_valid, req_ready 1 one edge after release.
REQ-043 Writes 0x11..0x1B to addrs 0..10 then reads 0..10 -> each rsp_data matches, no rsp_err.
